// File: rtl/left_shift_seq_pkg.sv
// rtl/left_shift_seq_pkg.sv - shared state encodings, defaults and sizing helper for left_shift_seq
package left_shift_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SHW   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Bits needed to hold a stage index 0..shw-1.
    function automatic int stage_idx_width(input int shw);
        return (shw > 1) ? $clog2(shw) : 1;
    endfunction

endpackage

// File: rtl/left_shift_stage.sv
// rtl/left_shift_stage.sv - one barrel-shifter stage: optional left shift by 2^k with lost-ones detect
module left_shift_stage #(
    parameter int WIDTH = 32,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] value,
    input  logic [KW-1:0]    k,
    input  logic             enable,
    output logic [WIDTH-1:0] shifted,
    output logic             lost
);

    logic [WIDTH-1:0] shifted_all;
    logic [WIDTH-1:0] top_bits;

    // Shift by 2^k and isolate the 2^k top bits that would fall off the end.
    always_comb begin
        shifted_all = value << (1 << k);
        top_bits    = value >> (WIDTH - (1 << k));
        shifted     = enable ? shifted_all : value;
        lost        = enable & (|top_bits);
    end

endmodule

// File: rtl/left_shift_seq.sv
// rtl/left_shift_seq.sv - sequential left shifter, one binary stage per clock, fixed latency
module left_shift_seq
    import left_shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = DEFAULT_SHW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_shift,
    input  logic [WIDTH-1:0] data_operand,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy,
    output logic             overflow
);

    localparam int KW = stage_idx_width(SHW);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   shamt_q;
    logic [KW-1:0]    stage;
    logic             ovf_q;
    logic             rdy_q;
    logic             busy_q;

    logic [WIDTH-1:0] stage_value;
    logic             stage_lost;

    // The single shared stage is steered by the current stage index each cycle.
    left_shift_stage #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_stage (
        .value   (acc),
        .k       (stage),
        .enable  (shamt_q[stage]),
        .shifted (stage_value),
        .lost    (stage_lost)
    );

    // Control FSM: capture at start, walk stages MSB first, pulse ready once, then idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            shamt_q <= '0;
            stage   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rdy_q <= 1'b0;
                    if (ctrl_shift) begin
                        acc     <= data_operand;
                        shamt_q <= shamt;
                        stage   <= KW'(SHW - 1);
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc   <= stage_value;
                    ovf_q <= ovf_q | stage_lost;
                    if (stage == '0) begin
                        rdy_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        stage <= stage - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Requests seen here are dropped; a new start needs the next IDLE edge.
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_result    = acc;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_left_shift_seq.sv
// tb/tb_left_shift_seq.sv - self-checking bench for left_shift_seq
module tb_left_shift_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ctrl_shift = 1'b0;
    logic [31:0] data_operand = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;
    logic        overflow;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] op;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    left_shift_seq #(.WIDTH(32), .SHW(5)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_shift     (ctrl_shift),
        .data_operand   (data_operand),
        .shamt          (shamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start one operation, scramble inputs while it runs, check timing every cycle.
    task automatic run_op(input string name, input logic [31:0] op, input logic [4:0] sh,
                          input logic [31:0] er, input logic eo);
        @(negedge clock);
        ctrl_shift   = 1'b1;
        data_operand = op;
        shamt        = sh;
        @(posedge clock);
        for (int e = 0; e <= 6; e++) begin
            @(negedge clock);
            ctrl_shift   = 1'b0;
            data_operand = $urandom;
            shamt        = 5'($urandom);
            chk({name, " busy"}, 32'(busy), (e <= 5) ? 32'd1 : 32'd0);
            chk({name, " rdy"}, 32'(data_resultRDY), (e == 5) ? 32'd1 : 32'd0);
            if (e >= 5) begin
                chk({name, " result"}, data_result, er);
                chk({name, " overflow"}, 32'(overflow), 32'(eo));
            end
            if (e < 6) @(posedge clock);
        end
    endtask

    initial begin
        int          pulses;
        int          rdy_at[$];
        logic [31:0] rop;
        logic [4:0]  rsh;
        logic [63:0] wide;

        vecs[0]  = '{32'h00000001, 5'd31, 32'h80000000, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 5'd16, 32'hFFFF0000, 1'b1};
        vecs[2]  = '{32'h12345678, 5'd0,  32'h12345678, 1'b0};
        vecs[3]  = '{32'h80000000, 5'd1,  32'h00000000, 1'b1};
        vecs[4]  = '{32'h00000003, 5'd30, 32'hC0000000, 1'b0};
        vecs[5]  = '{32'h00000007, 5'd30, 32'hC0000000, 1'b1};
        vecs[6]  = '{32'h0000ABCD, 5'd8,  32'h00ABCD00, 1'b0};
        vecs[7]  = '{32'h00010000, 5'd15, 32'h80000000, 1'b0};
        vecs[8]  = '{32'h00000000, 5'd31, 32'h00000000, 1'b0};
        vecs[9]  = '{32'h40000000, 5'd2,  32'h00000000, 1'b1};
        vecs[10] = '{32'h12345678, 5'd4,  32'h23456780, 1'b1};
        vecs[11] = '{32'hF0F0F0F0, 5'd5,  32'h1E1E1E00, 1'b1};

        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("reset result", data_result, 32'h0);
        chk("reset rdy", 32'(data_resultRDY), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset overflow", 32'(overflow), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sh, vecs[i].res, vecs[i].ovf);

        // Requests during SHIFT/DONE are dropped, operand changes ignored.
        @(negedge clock);
        ctrl_shift   = 1'b1;
        data_operand = 32'h00000003;
        shamt        = 5'd2;
        pulses       = 0;
        for (int e = 0; e < 16; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) pulses++;
            if (e == 5) chk("drop result", data_result, 32'h0000000C);
            data_operand = $urandom;
            shamt        = 5'($urandom);
            ctrl_shift   = (e < 5);
        end
        chk("drop pulses", 32'(pulses), 32'd1);
        chk("drop idle busy", 32'(busy), 32'd0);
        chk("drop held result", data_result, 32'h0000000C);

        // Back-to-back: held request restarts only on the edge after DONE->IDLE.
        @(negedge clock);
        ctrl_shift   = 1'b1;
        data_operand = 32'h00000001;
        shamt        = 5'd1;
        for (int e = 0; e < 14; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) rdy_at.push_back(e);
            if (e == 6) chk("b2b idle gap busy", 32'(busy), 32'd0);
            ctrl_shift = (e < 7);
        end
        chk("b2b pulse count", 32'(rdy_at.size()), 32'd2);
        if (rdy_at.size() == 2) begin
            chk("b2b first pulse", 32'(rdy_at[0]), 32'd5);
            chk("b2b second pulse", 32'(rdy_at[1]), 32'd12);
        end
        chk("b2b result", data_result, 32'h00000002);

        // Reset in the third SHIFT cycle aborts with no ready pulse.
        @(negedge clock);
        ctrl_shift   = 1'b1;
        data_operand = 32'hFFFFFFFF;
        shamt        = 5'd31;
        @(posedge clock);
        @(negedge clock);
        ctrl_shift = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort result", data_result, 32'h0);
        chk("abort rdy", 32'(data_resultRDY), 32'h0);
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort overflow", 32'(overflow), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pulses  = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY || busy) pulses++;
        end
        chk("abort quiet", 32'(pulses), 32'd0);
        run_op("post reset", 32'h0000000F, 5'd4, 32'h000000F0, 1'b0);

        // Random sweep against a wide-shift reference.
        for (int i = 0; i < 1000; i++) begin
            rop  = $urandom;
            rsh  = 5'($urandom_range(0, 31));
            wide = {32'h0, rop} << rsh;
            run_op("rand", rop, rsh, wide[31:0], |wide[63:32]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
